// File: rtl/arb_pkg.sv
// Shared types for the ibus/dbus memory port arbiter: channel structs,
// FSM and owner enums, and the fixed fetch transfer size.
package arb_pkg;

  localparam int ARB_ADDR_W = 64;
  localparam int ARB_DATA_W = 64;
  localparam int ARB_STRB_W = ARB_DATA_W / 8;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Instruction fetches always move one 32-bit word.
  localparam msize_t IBUS_FETCH_SIZE = MSIZE4;

  typedef struct packed {
    logic                  valid;
    logic [ARB_ADDR_W-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic                  valid;
    logic [ARB_ADDR_W-1:0] addr;
    msize_t                size;
    logic [ARB_STRB_W-1:0] strobe;
    logic [ARB_DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic                  addr_ok;
    logic                  data_ok;
    logic [ARB_DATA_W-1:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_write;
    logic [ARB_ADDR_W-1:0] addr;
    msize_t                size;
    logic [ARB_STRB_W-1:0] strobe;
    logic [ARB_DATA_W-1:0] data;
  } mport_req_t;

  typedef struct packed {
    logic                  ready;
    logic                  data_ok;
    logic [ARB_DATA_W-1:0] data;
  } mport_resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_grant.sv
// Combinational winner select between ibus and dbus.
// Build option ARB_ROUND_ROBIN_EN: alternate on collisions using last grant;
// otherwise dbus always beats ibus.
module arb_grant
  import arb_pkg::*;
(
  input  logic       i_iValid,
  input  logic       i_dValid,
`ifdef ARB_ROUND_ROBIN_EN
  input  arb_owner_t i_lastGrant,
`endif
  output logic       o_anyValid,
  output arb_owner_t o_winner
);

  // Pick a winner; a lone requester always wins, collisions follow the policy.
  always_comb begin
    o_anyValid = i_iValid | i_dValid;
    o_winner   = OWNER_D;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_iValid && i_dValid) begin
      o_winner = (i_lastGrant == OWNER_D) ? OWNER_I : OWNER_D;
    end else if (i_iValid) begin
      o_winner = OWNER_I;
    end
`else
    if (i_iValid && !i_dValid) begin
      o_winner = OWNER_I;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (ibus) and data (dbus).
// One request is latched at a time, issued, and its response routed back.
// Build option ARB_ROUND_ROBIN_EN selects round-robin collision handling.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic        clk,
  input  logic        reset,
  input  ibus_req_t   ireq,
  output ibus_resp_t  iresp,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output mport_req_t  mreq,
  input  mport_resp_t mresp
);

  arb_state_t            r_state;
  arb_state_t            w_stateNext;
  arb_owner_t            r_owner;
  logic                  r_isWrite;
  logic [ADDR_W-1:0]     r_addr;
  msize_t                r_size;
  logic [DATA_W/8-1:0]   r_strobe;
  logic [DATA_W-1:0]     r_data;
  logic                  r_abandon;

  logic                  w_anyValid;
  arb_owner_t            w_winner;
  logic                  w_grantTake;
  logic                  w_ownerValid;
  logic                  w_complete;
  logic                  w_drop;
  logic                  w_abandonFire;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t            r_lastGrant;

  // Remember who finished last so the next collision goes the other way.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastGrant <= OWNER_D;
    end else if (w_complete) begin
      r_lastGrant <= r_owner;
    end
  end
`endif

  arb_grant u_grant (
    .i_iValid    (ireq.valid),
    .i_dValid    (dreq.valid),
`ifdef ARB_ROUND_ROBIN_EN
    .i_lastGrant (r_lastGrant),
`endif
    .o_anyValid  (w_anyValid),
    .o_winner    (w_winner)
  );

  assign w_grantTake   = (r_state == IDLE) && w_anyValid;
  assign w_ownerValid  = (r_owner == OWNER_I) ? ireq.valid : dreq.valid;
  assign w_complete    = ((r_state == ISSUE) && mresp.ready && mresp.data_ok) ||
                         ((r_state == WAIT) && mresp.data_ok);
  assign w_drop        = r_abandon | ~w_ownerValid;
  assign w_abandonFire = w_complete & w_drop;

  // A transaction whose owner walked away still finishes on the memory port.
  arb_abandon: cover property (@(posedge clk) disable iff (reset) w_abandonFire);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: grant in IDLE, hold ISSUE until accepted, hold WAIT until data.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_anyValid) w_stateNext = ISSUE;
      ISSUE:   if (mresp.ready) w_stateNext = mresp.data_ok ? IDLE : WAIT;
      WAIT:    if (mresp.data_ok) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Capture the winner's fields so requester changes cannot corrupt the issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner   <= OWNER_D;
      r_isWrite <= 1'b0;
      r_addr    <= '0;
      r_size    <= MSIZE1;
      r_strobe  <= '0;
      r_data    <= '0;
      r_abandon <= 1'b0;
    end else if (w_grantTake) begin
      r_owner   <= w_winner;
      r_abandon <= 1'b0;
      if (w_winner == OWNER_I) begin
        r_isWrite <= 1'b0;
        r_addr    <= ireq.addr;
        r_size    <= IBUS_FETCH_SIZE;
        r_strobe  <= '0;
        r_data    <= '0;
      end else begin
        r_isWrite <= |dreq.strobe;
        r_addr    <= dreq.addr;
        r_size    <= dreq.size;
        r_strobe  <= dreq.strobe;
        r_data    <= dreq.data;
      end
    end else if ((r_state != IDLE) && !w_ownerValid) begin
      r_abandon <= 1'b1;
    end
  end

  // Drive the memory request and route handshakes/data back to the owner.
  always_comb begin
    mreq  = '0;
    iresp = '0;
    dresp = '0;
    if (!reset) begin
      mreq.valid    = (r_state == ISSUE);
      mreq.is_write = r_isWrite;
      mreq.addr     = r_addr;
      mreq.size     = r_size;
      mreq.strobe   = r_strobe;
      mreq.data     = r_data;
      iresp.data    = r_addr[2] ? mresp.data[63:32] : mresp.data[31:0];
      dresp.data    = mresp.data;
      if (w_grantTake) begin
        if (w_winner == OWNER_I) iresp.addr_ok = 1'b1;
        else                     dresp.addr_ok = 1'b1;
      end
      if (w_complete && !w_drop) begin
        if (r_owner == OWNER_I) iresp.data_ok = mresp.data_ok;
        else                    dresp.data_ok = mresp.data_ok;
      end
    end
  end

endmodule
